// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_owner_t;

  localparam logic [2:0] MEM_FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic with a bounded burst hold for the owner.
module rr_arb2
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic [1:0] req,
  input  arb_owner_t owner,
  input  logic       owner_valid,
  input  logic [3:0] burst_cnt,
  output logic [1:0] gnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  logic keep_owner;

  // Under contention the owner keeps the port only while its current run is
  // unbroken and below the burst allowance; otherwise the other side goes.
  assign keep_owner = owner_valid && (burst_cnt < MAX_CNT);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (keep_owner) gnt = (owner == ARB_M1) ? 2'b10 : 2'b01;
        else            gnt = (owner == ARB_M1) ? 2'b01 : 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between m0 (CPU) and m1 (DMA/loader); read data is
// steered back by a registered owner tag. Optional counters: MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_funct3,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_funct3,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_ra,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rd
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] m0_grant_cnt,
  output logic [31:0] m1_grant_cnt,
  output logic [31:0] contention_cnt
`endif
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  logic [1:0] gnt;
  logic       owner_valid;
  logic [3:0] burst_cnt;
  logic       rd_pend;
  arb_owner_t owner;
  arb_owner_t rd_owner;
  arb_owner_t grant_idx;
  logic       any_gnt;

  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_rr_arb2 (
    .req         ({m1_req, m0_req}),
    .owner       (owner),
    .owner_valid (owner_valid),
    .burst_cnt   (burst_cnt),
    .gnt         (gnt)
  );

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign any_gnt   = |gnt;
  assign grant_idx = gnt[1] ? ARB_M1 : ARB_M0;

  always_comb begin
    mem_wen    = 1'b0;
    mem_ra     = '0;
    mem_wa     = '0;
    mem_wd     = '0;
    mem_funct3 = MEM_FUNCT3_WORD;
    if (gnt[0]) begin
      mem_wen    = m0_we;
      mem_ra     = m0_addr;
      mem_wa     = m0_addr;
      mem_wd     = m0_wdata;
      mem_funct3 = m0_funct3;
    end else if (gnt[1]) begin
      mem_wen    = m1_we;
      mem_ra     = m1_addr;
      mem_wa     = m1_addr;
      mem_wd     = m1_wdata;
      mem_funct3 = m1_funct3;
    end
  end

  // Owner starts as m1 so that the first contention after reset goes to m0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner       <= ARB_M1;
      owner_valid <= 1'b0;
      burst_cnt   <= '0;
      rd_pend     <= 1'b0;
      rd_owner    <= ARB_M0;
    end else if (any_gnt) begin
      owner       <= grant_idx;
      owner_valid <= 1'b1;
      if (owner_valid && (grant_idx == owner))
        burst_cnt <= (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + 4'd1;
      else
        burst_cnt <= 4'd1;
      rd_pend     <= ~mem_wen;
      rd_owner    <= grant_idx;
    end else begin
      owner_valid <= 1'b0;
      burst_cnt   <= '0;
      rd_pend     <= 1'b0;
    end
  end

  assign m0_rvalid = rd_pend && (rd_owner == ARB_M0);
  assign m1_rvalid = rd_pend && (rd_owner == ARB_M1);
  assign m0_rdata  = mem_rd;
  assign m1_rdata  = mem_rd;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_grant_cnt   <= '0;
      m1_grant_cnt   <= '0;
      contention_cnt <= '0;
    end else begin
      if (gnt[0] && (m0_grant_cnt != 32'hFFFF_FFFF))
        m0_grant_cnt <= m0_grant_cnt + 32'd1;
      if (gnt[1] && (m1_grant_cnt != 32'hFFFF_FFFF))
        m1_grant_cnt <= m1_grant_cnt + 32'd1;
      if (m0_req && m1_req && (contention_cnt != 32'hFFFF_FFFF))
        contention_cnt <= contention_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized, model-checked bench for mem_arbiter at MAX_BURST=4 and 1.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rd;
  logic [2:0]  m0_funct3, m1_funct3;

  logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_wen;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_ra, a_mem_wa, a_mem_wd;
  logic [2:0]  a_mem_funct3;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_wen;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_ra, b_mem_wa, b_mem_wd;
  logic [2:0]  b_mem_funct3;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] a_m0_cnt, a_m1_cnt, a_cont_cnt, b_m0_cnt, b_m1_cnt, b_cont_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(4)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_funct3(m0_funct3),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_funct3(m1_funct3),
    .m0_gnt(a_m0_gnt), .m1_gnt(a_m1_gnt), .m0_rvalid(a_m0_rvalid), .m1_rvalid(a_m1_rvalid),
    .m0_rdata(a_m0_rdata), .m1_rdata(a_m1_rdata),
    .mem_wen(a_mem_wen), .mem_ra(a_mem_ra), .mem_wa(a_mem_wa), .mem_wd(a_mem_wd),
    .mem_funct3(a_mem_funct3), .mem_rd(mem_rd)
`ifdef MEM_ARB_STATS_EN
    , .m0_grant_cnt(a_m0_cnt), .m1_grant_cnt(a_m1_cnt), .contention_cnt(a_cont_cnt)
`endif
  );

  mem_arbiter #(.MAX_BURST(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_funct3(m0_funct3),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_funct3(m1_funct3),
    .m0_gnt(b_m0_gnt), .m1_gnt(b_m1_gnt), .m0_rvalid(b_m0_rvalid), .m1_rvalid(b_m1_rvalid),
    .m0_rdata(b_m0_rdata), .m1_rdata(b_m1_rdata),
    .mem_wen(b_mem_wen), .mem_ra(b_mem_ra), .mem_wa(b_mem_wa), .mem_wd(b_mem_wd),
    .mem_funct3(b_mem_funct3), .mem_rd(mem_rd)
`ifdef MEM_ARB_STATS_EN
    , .m0_grant_cnt(b_m0_cnt), .m1_grant_cnt(b_m1_cnt), .contention_cnt(b_cont_cnt)
`endif
  );

  // Reference model, one slot per instance: who held the port last, how long
  // its unbroken run is, and which read (if any) is due back next cycle.
  int maxb[2] = '{4, 1};
  int last_g[2];
  int streak[2];
  bit pend[2];
  int pend_who[2];
  int exp_ga = -1;

  localparam logic [99:0] IDLE_BUS = {1'b0, 32'h0, 32'h0, 32'h0, 3'b010};

  function automatic int pick(bit r0, bit r1, int last, int run, int allow);
    if (!r0 && !r1) return -1;
    if (r0 != r1) return r0 ? 0 : 1;
    if (run > 0 && run < allow) return last;
    return 1 - last;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        last_g[i] = 1; streak[i] = 0; pend[i] = 0; pend_who[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int g;
        g = pick(m0_req, m1_req, last_g[i], streak[i], maxb[i]);
        if (g < 0) begin
          streak[i] = 0;
          pend[i] = 0;
        end else begin
          if (streak[i] > 0 && g == last_g[i])
            streak[i] = (streak[i] + 1 > maxb[i]) ? maxb[i] : streak[i] + 1;
          else
            streak[i] = 1;
          last_g[i] = g;
          pend[i] = (g == 0) ? !m0_we : !m1_we;
          pend_who[i] = g;
        end
      end
    end
  end

  task automatic check_inst(int i, string tag, logic g0, logic g1, logic [99:0] bus,
                            logic rv0, logic rv1, logic [31:0] rd0, logic [31:0] rd1);
    int g;
    logic [99:0] ebus;
    g = pick(m0_req, m1_req, last_g[i], streak[i], maxb[i]);
    if (i == 0) exp_ga = g;
    if (g == 0)      ebus = {m0_we, m0_addr, m0_addr, m0_wdata, m0_funct3};
    else if (g == 1) ebus = {m1_we, m1_addr, m1_addr, m1_wdata, m1_funct3};
    else             ebus = IDLE_BUS;
    check({tag, "_gnt"}, 128'({g1, g0}), 128'({g == 1, g == 0}));
    check({tag, "_membus"}, 128'(bus), 128'(ebus));
    check({tag, "_rvalid"}, 128'({rv1, rv0}), 128'({pend[i] && pend_who[i] == 1, pend[i] && pend_who[i] == 0}));
    if (pend[i]) check({tag, "_rdata"}, 128'(pend_who[i] == 1 ? rd1 : rd0), 128'(mem_rd));
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check_inst(0, "a", a_m0_gnt, a_m1_gnt, {a_mem_wen, a_mem_ra, a_mem_wa, a_mem_wd, a_mem_funct3},
                 a_m0_rvalid, a_m1_rvalid, a_m0_rdata, a_m1_rdata);
      check_inst(1, "b", b_m0_gnt, b_m1_gnt, {b_mem_wen, b_mem_ra, b_mem_wa, b_mem_wd, b_mem_funct3},
                 b_m0_rvalid, b_m1_rvalid, b_m0_rdata, b_m1_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(int k, bit we, logic [31:0] addr, logic [31:0] data, logic [2:0] f3);
    if (k == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = data; m0_funct3 = f3;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = data; m1_funct3 = f3;
    end
  endtask

  task automatic do_reset();
    m0_req = 1'b0; m1_req = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_funct3 = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_funct3 = 0;
    mem_rd = 0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_flags", 128'({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid}), 128'(0));
    checkOutput("reset_bus", 128'({a_mem_wen, a_mem_ra, a_mem_wa, a_mem_wd, a_mem_funct3}), 128'(IDLE_BUS));
    step();
    reset_n = 1'b1;

    // Lone m0 read at 0x100
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 3'b010);
    sample();
    checkOutput("rd_m0_gnt", 128'({a_m1_gnt, a_m0_gnt}), 128'(2'b01));
    checkOutput("rd_m0_ra", 128'(a_mem_ra), 128'(32'h100));
    step();
    m0_req = 1'b0; mem_rd = 32'hDEADBEEF;
    sample();
    checkOutput("rd_m0_rvalid", 128'({a_m1_rvalid, a_m0_rvalid}), 128'(2'b01));
    checkOutput("rd_m0_rdata", 128'(a_m0_rdata), 128'(32'hDEADBEEF));

    // Continuous contention from reset
    step();
    do_reset();
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 3'b010);
    applyStimulus(1, 1'b0, 32'h20, 32'h0, 3'b010);
    for (int k = 0; k < 12; k++) begin
      sample();
      checkOutput($sformatf("burst4_%0d", k), 128'({a_m1_gnt, a_m0_gnt}),
                  128'((k >= 4 && k < 8) ? 2'b10 : 2'b01));
      checkOutput($sformatf("burst1_%0d", k), 128'({b_m1_gnt, b_m0_gnt}),
                  128'((k % 2) ? 2'b10 : 2'b01));
      step();
    end
    m0_req = 1'b0; m1_req = 1'b0;

    // Lone m1 byte write
    step();
    applyStimulus(1, 1'b1, 32'h200, 32'h12345678, 3'b000);
    sample();
    checkOutput("wr_m1_bus", 128'({a_m1_gnt, a_mem_wen, a_mem_wa, a_mem_wd, a_mem_funct3}),
                128'({1'b1, 1'b1, 32'h200, 32'h12345678, 3'b000}));
    step();
    m1_req = 1'b0;
    sample();
    checkOutput("wr_m1_norv", 128'({a_m1_rvalid, a_m0_rvalid, a_mem_wen}), 128'(0));

    // Alternating reads with tagged returns
    step();
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 3'b010);
    step();
    m0_req = 1'b0; mem_rd = 32'hAAAA0000;
    applyStimulus(1, 1'b0, 32'h4, 32'h0, 3'b010);
    sample();
    checkOutput("alt_ret0", 128'({a_m1_rvalid, a_m0_rvalid, a_m0_rdata}), 128'({2'b01, 32'hAAAA0000}));
    step();
    m1_req = 1'b0; mem_rd = 32'hBBBB0004;
    applyStimulus(0, 1'b0, 32'h8, 32'h0, 3'b010);
    sample();
    checkOutput("alt_ret1", 128'({a_m1_rvalid, a_m0_rvalid, a_m1_rdata}), 128'({2'b10, 32'hBBBB0004}));
    step();
    m0_req = 1'b0; mem_rd = 32'hCCCC0008;
    sample();
    checkOutput("alt_ret2", 128'({a_m1_rvalid, a_m0_rvalid, a_m0_rdata}), 128'({2'b01, 32'hCCCC0008}));

    // Reset pulse between a read grant and its return
    step();
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 3'b010);
    sample();
    checkOutput("rst_rd_gnt", 128'(a_m0_gnt), 128'(1'b1));
    reset_n = 1'b0; m0_req = 1'b0;
    #1;
    checkOutput("rst_idle", 128'({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_wen, a_mem_ra,
                                  a_mem_wa, a_mem_wd, a_mem_funct3}), 128'({4'b0, IDLE_BUS}));
    #1;
    reset_n = 1'b1;
    sample();
    checkOutput("rst_no_rvalid", 128'({a_m1_rvalid, a_m0_rvalid}), 128'(0));
    step();
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 3'b010);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 3'b010);
    sample();
    checkOutput("rst_first_cont", 128'({a_m1_gnt, a_m0_gnt}), 128'(2'b01));
    step();
    m0_req = 1'b0; m1_req = 1'b0;

`ifdef MEM_ARB_STATS_EN
    step();
    do_reset();
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 3'b010);
    applyStimulus(1, 1'b0, 32'h4, 32'h0, 3'b010);
    step();
    step();
    step();
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    step();
    sample();
    checkOutput("stats_cont", 128'(a_cont_cnt), 128'(32'd3));
    checkOutput("stats_grants", 128'(a_m0_cnt + a_m1_cnt), 128'(32'd3));
`endif

    // Random traffic: requests held until granted, occasional withdrawal
    for (int c = 0; c < 3000; c++) begin
      step();
      mem_rd = $urandom;
      for (int k = 0; k < 2; k++) begin
        bit cur;
        cur = (k == 0) ? m0_req : m1_req;
        if ((cur && exp_ga == k) || !cur) begin
          if ($urandom_range(99) < 45)
            applyStimulus(k, $urandom_range(1) == 1, {$urandom_range(255), 2'b00}, $urandom,
                          3'($urandom_range(7)));
          else if (k == 0) m0_req = 1'b0;
          else m1_req = 1'b0;
        end else if ($urandom_range(15) == 0) begin
          if (k == 0) m0_req = 1'b0;
          else m1_req = 1'b0;
        end
      end
      if (c % 401 == 200) begin
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
